// File: rtl/serial_scratchpad_pkg.sv
// Shared types and default geometry for the bit-serial scratchpad.
package serial_scratchpad_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        WR_SHIFT,
        RD_FETCH,
        RD_SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/serial_scratchpad_if.sv
// Command, serial-in, serial-out, status and debug signals of the scratchpad.
// The master drives commands and serial input; the slave is the scratchpad itself.
interface serial_scratchpad_if
    import serial_scratchpad_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          sin_valid;
    logic          sin_bit;
    logic          sin_ready;
    logic          sout_valid;
    logic          sout_bit;
    logic          sout_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, sin_valid, sin_bit,
               sout_ready, dbg_addr,
        input  cmd_ready, sin_ready, sout_valid, sout_bit, busy, done, dbg_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, sin_valid, sin_bit,
               sout_ready, dbg_addr,
        output cmd_ready, sin_ready, sout_valid, sout_bit, busy, done, dbg_data
    );

endinterface

// File: rtl/scratch_ram_1w2r.sv
// DEPTH x WIDTH RAM: core write/read port plus registered debug read port, 1-cycle latency.
// Both read ports return pre-write data on a same-address write; no backpressure.
module scratch_ram_1w2r #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= mem[dbg_addr];
        end
    end

endmodule

// File: rtl/serial_scratchpad.sv
// Bit-serial burst writer/reader over an on-chip RAM; read words start 2 cycles after command.
// Serial input stalls on sin_valid, serial output holds each bit until sout_ready.
module serial_scratchpad
    import serial_scratchpad_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_scratchpad_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [AW:0]   REM_ONE  = (AW + 1)'(1);

    state_e           state, state_d;
    logic [AW-1:0]    addr, addr_d, core_addr;
    logic [AW:0]      rem;
    logic [BW-1:0]    bitcnt;
    logic [WIDTH-1:0] shreg, rd_data, wr_word;
    logic             cmd_fire, wr_fire, rd_fire, last_bit, word_end, wr_en;

    assign cmd_fire = (state == IDLE) && bus.cmd_valid;
    assign wr_fire  = (state == WR_SHIFT) && bus.sin_valid;
    assign rd_fire  = (state == RD_SHIFT) && bus.sout_ready;
    assign last_bit = (bitcnt == LAST_BIT);
    assign word_end = (wr_fire || rd_fire) && last_bit;
    assign wr_en    = wr_fire && last_bit;
    assign wr_word  = {shreg[WIDTH-2:0], bus.sin_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0)  state_d = DONE;
                    else if (bus.cmd_write) state_d = WR_SHIFT;
                    else                    state_d = RD_FETCH;
                end
            end
            WR_SHIFT: if (word_end && rem == REM_ONE) state_d = DONE;
            RD_FETCH: state_d = RD_SHIFT;
            RD_SHIFT: if (word_end) state_d = (rem == REM_ONE) ? DONE : RD_FETCH;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr;
        if (cmd_fire)      addr_d = bus.cmd_addr;
        else if (word_end) addr_d = addr + AW'(1);
    end

    // Reads look up the address the next cycle will hold, so the word is
    // already in rd_data during RD_FETCH and lands in shreg on leaving it.
    assign core_addr = wr_en ? addr : addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr   <= '0;
            rem    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            addr <= addr_d;
            if (cmd_fire) begin
                rem    <= bus.cmd_len;
                bitcnt <= '0;
            end
            if (state == RD_FETCH) begin
                shreg  <= rd_data;
                bitcnt <= '0;
            end
            if (wr_fire || rd_fire) begin
                shreg  <= wr_fire ? wr_word : {shreg[WIDTH-2:0], 1'b0};
                bitcnt <= last_bit ? '0 : bitcnt + BW'(1);
                if (last_bit) rem <= rem - REM_ONE;
            end
        end
    end

    scratch_ram_1w2r #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .addr     (core_addr),
        .wdata    (wr_word),
        .rdata    (rd_data),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data)
    );

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.sin_ready  = (state == WR_SHIFT);
    assign bus.sout_valid = (state == RD_SHIFT);
    assign bus.sout_bit   = (state == RD_SHIFT) && shreg[WIDTH-1];
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_serial_scratchpad.sv
// Directed bench for serial_scratchpad with a reference memory and expected-value queues.
module tb_serial_scratchpad;

    localparam int W = 8;
    localparam int D = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_scratchpad_if #(.WIDTH(W), .DEPTH(D)) bus ();
    serial_scratchpad #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] model [D];
    logic [W-1:0] wr_words [$];
    logic [W-1:0] dbg_q [$];
    logic         bit_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic w, input int a, input int l);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = 6'(a);
        bus.cmd_len   = 7'(l);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic dbg_chk(input string tag, input int a);
        bus.dbg_addr = 6'(a);
        dbg_q.push_back(model[a]);
        @(posedge clk);
        @(negedge clk);
        chk(tag, 32'(bus.dbg_data), 32'(dbg_q.pop_front()));
        step();
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nbits, input bit check_first);
        for (int b = 0; b < nbits; b++) begin
            bus.sin_valid = 1'b1;
            bus.sin_bit   = w[W-1-b];
            @(negedge clk);
            if (check_first && b == 0) chk("wr_busy_sin_ready", {bus.busy, bus.sin_ready}, 2'b11);
            step();
        end
        bus.sin_valid = 1'b0;
    endtask

    task automatic wr_burst(input int a, input int l);
        logic [W-1:0] w;
        cmd(1'b1, a, l);
        for (int k = 0; k < l; k++) begin
            w = wr_words.pop_front();
            send_bits(w, W, k == 0);
            model[(a + k) % D] = w;
        end
        @(negedge clk);
        chk("wr_done_pulse", bus.done, 1'b1);
        step();
        @(negedge clk);
        chk("wr_ready_back", {bus.done, bus.cmd_ready}, 2'b01);
        step();
    endtask

    task automatic rd_burst(input int a, input int l, input bit toggle);
        int  first = -1;
        int  done_i = -1;
        int  i = 0;
        for (int k = 0; k < l; k++)
            for (int b = W - 1; b >= 0; b--) bit_q.push_back(model[(a + k) % D][b]);
        cmd(1'b0, a, l);
        while (done_i < 0 && i < 400) begin
            bus.sout_ready = toggle ? (i % 2 == 1) : 1'b1;
            bus.sin_valid  = 1'($urandom_range(0, 1));
            bus.sin_bit    = 1'b1;
            @(negedge clk);
            if (bus.sout_valid && first < 0) first = i;
            if (bus.done) done_i = i;
            if (bus.sout_valid && bus.sout_ready) begin
                if (bit_q.size() == 0) chk("rd_extra_bit", 1, 0);
                else chk("rd_bit", bus.sout_bit, bit_q.pop_front());
            end
            step();
            i++;
        end
        bus.sout_ready = 1'b0;
        bus.sin_valid  = 1'b0;
        chk("rd_first_valid_cycle", first, 1);
        chk("rd_bits_left", bit_q.size(), 0);
        if (!toggle) chk("rd_burst_cycles", done_i, l * (W + 1));
        else chk("rd_done_seen", done_i >= 0, 1);
        bit_q.delete();
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.sin_valid = 0; bus.sin_bit = 0; bus.sout_ready = 0; bus.dbg_addr = '0;

        // Reset values
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {bus.cmd_ready, bus.sin_ready, bus.sout_valid, bus.sout_bit, bus.busy, bus.done}, 6'b100000);
        chk("reset_dbg_data", 32'(bus.dbg_data), 0);
        step();
        rst = 1'b0;
        step();

        // Single word at address 5
        wr_words.push_back(8'hA5);
        wr_burst(5, 1);
        dbg_chk("dbg_addr5", 5);

        // Three words wrapping past the top address
        wr_words.push_back(8'h11);
        wr_words.push_back(8'h22);
        wr_words.push_back(8'h33);
        wr_burst(62, 3);
        dbg_chk("dbg_addr62", 62);
        dbg_chk("dbg_addr63", 63);
        dbg_chk("dbg_addr0_wrap", 0);

        // sin_valid noise while idle must not touch memory
        for (int i = 0; i < 10; i++) begin
            bus.sin_valid = 1'b1;
            bus.sin_bit   = 1'b0;
            step();
        end
        bus.sin_valid = 1'b0;

        // Read two words with a stuttering consumer and sin_valid noise
        rd_burst(62, 2, 1'b1);
        dbg_chk("dbg_addr62_after_rd", 62);
        dbg_chk("dbg_addr63_after_rd", 63);

        // Zero-length command
        cmd(1'b1, 5, 0);
        @(negedge clk);
        chk("len0_done", {bus.done, bus.cmd_ready}, 2'b10);
        step();
        @(negedge clk);
        chk("len0_ready_back", {bus.done, bus.cmd_ready}, 2'b01);
        step();
        dbg_chk("len0_ram_unchanged", 5);

        // Reset in the middle of the second word of a burst
        wr_words.push_back(8'h5A);
        wr_burst(21, 1);
        cmd(1'b1, 20, 2);
        send_bits(8'h3C, W, 1'b0);
        model[20] = 8'h3C;
        send_bits(8'hFF, 4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midburst_reset_idle", {bus.cmd_ready, bus.busy, bus.sin_ready}, 3'b100);
        step();
        rst = 1'b0;
        step();
        dbg_chk("reset_kept_word", 20);
        dbg_chk("reset_partial_dropped", 21);

        // Full-rate reads across the wrap boundary and after the reset
        rd_burst(20, 2, 1'b0);
        rd_burst(63, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_scratchpad.md
# serial_scratchpad

Parametrised serial-load scratchpad: a bit-serial stream is assembled MSB-first into WIDTH-bit words and written to an on-chip RAM at an auto-incrementing address, and stored words are streamed back bit-serially under a ready/valid handshake. Bursts of 1..DEPTH words are started by a command. A parallel debug read port is always live. It sits between the pin-level I/O wrapper and on-chip storage, replacing the fixed 8-bit × 64 shift-and-store scheme.

## Interface
- WIDTH, 8, word width in bits (≥2)
- DEPTH, 64, words of storage (power of two); AW = $clog2(DEPTH), derived
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = serial write burst, 0 = serial read burst
- cmd_addr  in  AW  burst start address
- cmd_len  in  AW+1  burst length in words, 0..DEPTH
- sin_valid  in  1  serial input bit valid
- sin_bit  in  1  serial input bit, MSB of each word first
- sin_ready  out  1  high in WR_SHIFT
- sout_valid  out  1  serial output bit valid
- sout_bit  out  1  serial output bit, MSB first
- sout_ready  in  1  consumer accepts bit
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at burst end
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  registered debug read data

## Operation
- States: IDLE, WR_SHIFT, RD_FETCH, RD_SHIFT, DONE.
- IDLE: a command is accepted when cmd_valid && cmd_ready. The block latches addr ← cmd_addr and rem ← cmd_len.
  - cmd_len = 0 → DONE.
  - Otherwise cmd_write=1 → WR_SHIFT, and cmd_write=0 → RD_FETCH.
- WR_SHIFT: each sin_valid cycle shifts sin_bit into the shift register and increments the bit counter.
  - On the WIDTH-th bit, mem[addr] ← {shreg[WIDTH-2:0], sin_bit} in that same cycle.
  - Then addr ← addr+1 mod DEPTH, rem ← rem−1, and the bit counter clears.
  - If rem becomes 0 → DONE; otherwise stay in WR_SHIFT.
- RD_FETCH: the RAM read of mem[addr] is issued. The next state is RD_SHIFT, where the shift register loads the read data.
- RD_SHIFT: sout_valid=1 and sout_bit=shreg MSB. Each sout_ready cycle shifts left and counts.
  - After the WIDTH-th accepted bit: addr+1 mod DEPTH, rem−1.
  - rem = 0 → DONE; otherwise → RD_FETCH.
- DONE: done=1 for one cycle, then → IDLE.
- sin_valid outside WR_SHIFT and sout_ready outside RD_SHIFT are ignored.
- Debug port: dbg_data ← mem[dbg_addr] every cycle. On a same-address write in the same cycle, it returns the old data.
- Reset, including mid-burst: state → IDLE, and the partial word is discarded. Words already committed are retained. RAM contents are not reset.

## Timing
- Reset values: cmd_ready=1, sin_ready=0, sout_valid=0, sout_bit=0, busy=0, done=0, dbg_data=0.
- Command accepted at edge N:
  - busy=1 from N+1.
  - Write: sin_ready=1 from N+1.
  - Read: sout_valid=1 with the first MSB from N+2.
- Write burst of L words with back-to-back bits: last bit accepted at N+L·WIDTH, done high in the next cycle, cmd_ready high one cycle after that.
- Read: a one-cycle bubble (sout_valid=0, the RD_FETCH cycle) between words. With sout_ready held high, an L-word burst occupies L·(WIDTH+1) cycles from N+1.
- Address wrap: a burst starting at DEPTH−1 continues at address 0.
- cmd_len = DEPTH covers every location exactly once.
- The debug port has 1-cycle latency.

## Structure
- Package serial_scratchpad_pkg holds the state enum (IDLE, WR_SHIFT, RD_FETCH, RD_SHIFT, DONE) and the default WIDTH/DEPTH constants.
- Sub-module scratch_ram_1w2r: DEPTH×WIDTH RAM with one write/read port (core) and one registered read port (debug). Both read ports have read-old-data semantics.
- The FSM, shift register, bit counter, address and remaining-count registers live in serial_scratchpad.

## Test plan
- Write 1 word at addr 5, bits 1,0,1,0,0,1,0,1 → dbg_addr=5 shows 0xA5 after 1 cycle; done pulses once.
- Write 3 words 0x11,0x22,0x33 at addr 62 (WIDTH=8, DEPTH=64) → mem[62]=0x11, mem[63]=0x22, mem[0]=0x33 (wrap).
- Read 2 words from addr 62, sout_ready toggled every other cycle → exact 16-bit sequence 0x11 then 0x22 MSB-first, with no bit dropped or duplicated.
- cmd_len=0 → done high at N+1, cmd_ready back at N+2, RAM unchanged.
- Assert rst after 4 bits of the second word of a write burst → IDLE next cycle; first word retained, target of the second word unchanged.
- sin_valid pulses during a read burst and during IDLE → no RAM change, no effect on the output stream.
